// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the multi-digit BCD up/down counter.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  localparam int BCD_WRAP = 0;
  localparam int BCD_SAT  = 1;

  // Non-decimal nibbles (A..F) are forced to the largest legal digit.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_counter_n_if.sv
// Strobe/load/count bundle between a driver and the BCD counter.
interface bcd_counter_n_if #(
  parameter int DIGITS = 4
);

  logic                  inc;
  logic                  dec;
  logic                  clear;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   val;
  logic                  carry;
  logic                  borrow;
  logic                  zero;

  modport master (
    output inc, dec, clear, load, load_val,
    input  val, carry, borrow, zero
  );

  modport slave (
    input  inc, dec, clear, load, load_val,
    output val, carry, borrow, zero
  );

endinterface

// File: rtl/bcd_digit_updn.sv
// One BCD digit register with clear/load/up/down next-state and ripple outputs.
module bcd_digit_updn
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       up,
  input  logic       dn,
  input  logic       ci,
  input  logic       bi,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] ld_digit,
  output logic       co,
  output logic       bo,
  output logic [3:0] d
);

  logic [3:0] d_q;
  logic [3:0] d_d;
  logic       step_up;
  logic       step_dn;

  assign step_up = up & ci;
  assign step_dn = dn & bi;
  assign co      = step_up & (d_q == BCD_MAX);
  assign bo      = step_dn & (d_q == BCD_MIN);
  assign d       = d_q;

  always_comb begin
    // NOTE: d_d gets a default first so every path assigns it and no latch is inferred.
    d_d = d_q;
    if (clear) begin
      d_d = BCD_MIN;
    end else if (load) begin
      d_d = bcd_clamp(ld_digit);
    end else if (step_up) begin
      d_d = (d_q == BCD_MAX) ? BCD_MIN : d_q + 4'd1;
    end else if (step_dn) begin
      d_d = (d_q == BCD_MIN) ? BCD_MAX : d_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_q <= BCD_MIN;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      d_q <= d_d;
    end
  end

endmodule

// File: rtl/bcd_counter_n.sv
// N-digit BCD up/down counter: strobe sync + edge detect, wrap/saturate, carry/borrow pulses.
module bcd_counter_n
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SATURATE = BCD_WRAP,
  parameter int SYNC_IN  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  bcd_counter_n_if.slave   bus
);

  logic [1:0]          inc_sync_q, inc_sync_d;
  logic [1:0]          dec_sync_q, dec_sync_d;
  logic                inc_hist_q, inc_hist_d;
  logic                dec_hist_q, dec_hist_d;
  logic                carry_q, carry_d;
  logic                borrow_q, borrow_d;
  logic                inc_tap, dec_tap;
  logic                inc_ev, dec_ev;
  logic                at_max, at_min;
  logic                up, dn;
  logic [4*DIGITS-1:0] val_w;

  always_comb begin
    inc_sync_d = {inc_sync_q[0], bus.inc};
    dec_sync_d = {dec_sync_q[0], bus.dec};
    // Without synchronisation a single register stage still sits ahead of the history flop.
    inc_tap    = (SYNC_IN != 0) ? inc_sync_q[1] : inc_sync_q[0];
    dec_tap    = (SYNC_IN != 0) ? dec_sync_q[1] : dec_sync_q[0];
    inc_hist_d = inc_tap;
    dec_hist_d = dec_tap;
    inc_ev     = inc_tap & ~inc_hist_q;
    dec_ev     = dec_tap & ~dec_hist_q;
  end

  always_comb begin
    at_max = 1'b1;
    at_min = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      at_max = at_max & (val_w[4*i +: 4] == BCD_MAX);
      at_min = at_min & (val_w[4*i +: 4] == BCD_MIN);
    end
    // Opposing events cancel; clear/load discard events rather than queue them.
    up = inc_ev & ~dec_ev & ~bus.clear & ~bus.load;
    dn = dec_ev & ~inc_ev & ~bus.clear & ~bus.load;
    if (SATURATE == BCD_SAT) begin
      up = up & ~at_max;
      dn = dn & ~at_min;
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic       ci_w, bi_w, co_w, bo_w;
    logic [3:0] d_w;

    if (i == 0) begin : g_first
      assign ci_w = 1'b1;
      assign bi_w = 1'b1;
    end else begin : g_next
      assign ci_w = g_digit[i-1].co_w;
      assign bi_w = g_digit[i-1].bo_w;
    end

    bcd_digit_updn u_digit (
      .clk      (clk),
      .reset_n  (reset_n),
      .up       (up),
      .dn       (dn),
      .ci       (ci_w),
      .bi       (bi_w),
      .clear    (bus.clear),
      .load     (bus.load),
      .ld_digit (bus.load_val[4*i +: 4]),
      .co       (co_w),
      .bo       (bo_w),
      .d        (d_w)
    );

    assign val_w[4*i +: 4] = d_w;
  end

  // Ripple out of the top digit is the wrap; in saturate mode the gating keeps it low.
  assign carry_d  = g_digit[DIGITS-1].co_w;
  assign borrow_d = g_digit[DIGITS-1].bo_w;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inc_sync_q <= '0;
      dec_sync_q <= '0;
      inc_hist_q <= 1'b0;
      dec_hist_q <= 1'b0;
      carry_q    <= 1'b0;
      borrow_q   <= 1'b0;
    end else begin
      inc_sync_q <= inc_sync_d;
      dec_sync_q <= dec_sync_d;
      inc_hist_q <= inc_hist_d;
      dec_hist_q <= dec_hist_d;
      carry_q    <= carry_d;
      borrow_q   <= borrow_d;
    end
  end

  assign bus.val    = val_w;
  assign bus.carry  = carry_q;
  assign bus.borrow = borrow_q;
  assign bus.zero   = (val_w == '0);

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed bench: wrap/sync, saturate/sync and wrap/unsynchronised counters share one stimulus.
module tb_bcd_counter_n;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         inc, dec, clear, load;
  logic [W-1:0] load_val;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bcd_counter_n_if #(.DIGITS(DIGITS)) if_w ();
  bcd_counter_n_if #(.DIGITS(DIGITS)) if_s ();
  bcd_counter_n_if #(.DIGITS(DIGITS)) if_f ();

  assign if_w.inc = inc;  assign if_w.dec = dec;  assign if_w.clear = clear;
  assign if_w.load = load; assign if_w.load_val = load_val;
  assign if_s.inc = inc;  assign if_s.dec = dec;  assign if_s.clear = clear;
  assign if_s.load = load; assign if_s.load_val = load_val;
  assign if_f.inc = inc;  assign if_f.dec = dec;  assign if_f.clear = clear;
  assign if_f.load = load; assign if_f.load_val = load_val;

  bcd_counter_n #(.DIGITS(DIGITS), .SATURATE(0), .SYNC_IN(1)) u_wrap (
    .clk(clk), .reset_n(reset_n), .bus(if_w.slave));
  bcd_counter_n #(.DIGITS(DIGITS), .SATURATE(1), .SYNC_IN(1)) u_sat (
    .clk(clk), .reset_n(reset_n), .bus(if_s.slave));
  bcd_counter_n #(.DIGITS(DIGITS), .SATURATE(0), .SYNC_IN(0)) u_fast (
    .clk(clk), .reset_n(reset_n), .bus(if_f.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] to_bcd(input int n);
    logic [W-1:0] r;
    int           v;
    v = n;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic pulse(input logic pi, input logic pd);
    inc = pi;
    dec = pd;
    tick();
    inc = 1'b0;
    dec = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load     = 1'b1;
    load_val = v;
    tick();
    load     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n  = 1'b0;
    inc      = 1'b0;
    dec      = 1'b0;
    clear    = 1'b0;
    load     = 1'b0;
    load_val = '0;
    tick();
    tick();
    check("rst_val",    if_w.val,    0);
    check("rst_zero",   if_w.zero,   1);
    check("rst_carry",  if_w.carry,  0);
    check("rst_borrow", if_w.borrow, 0);
    check("rst_fast",   if_f.val,    0);
    reset_n = 1'b1;
    tick();

    // Ten inc pulses, one cycle high every three cycles, tracking latency.
    for (int i = 0; i < 10; i++) begin
      inc = 1'b1;
      tick();
      check("lat_e0_wrap", if_w.val, to_bcd(i));
      inc = 1'b0;
      tick();
      check("lat_e1_wrap", if_w.val, to_bcd(i));
      check("lat_e1_fast", if_f.val, to_bcd(i + 1));
      tick();
      check("lat_e2_wrap", if_w.val, to_bcd(i + 1));
    end
    check("count10_wrap", if_w.val, 16'h0010);
    check("count10_sat",  if_s.val, 16'h0010);
    check("count10_fast", if_f.val, 16'h0010);

    // Wrap up from all-9.
    do_load(16'h9999);
    check("load9999", if_w.val, 16'h9999);
    inc = 1'b1;
    tick();
    inc = 1'b0;
    tick();
    check("wrapup_fast_val",   if_f.val,   16'h0000);
    check("wrapup_fast_carry", if_f.carry, 1);
    tick();
    check("wrapup_val",       if_w.val,    16'h0000);
    check("wrapup_carry",     if_w.carry,  1);
    check("wrapup_borrow",    if_w.borrow, 0);
    check("wrapup_zero",      if_w.zero,   1);
    check("wrapup_sat_val",   if_s.val,    16'h9999);
    check("wrapup_sat_carry", if_s.carry,  0);
    check("wrapup_fast_done", if_f.carry,  0);
    tick();
    check("wrapup_carry_end", if_w.carry, 0);

    // Wrap down from all-0.
    do_load(16'h0000);
    check("load0000_zero", if_w.zero, 1);
    pulse(1'b0, 1'b1);
    check("wrapdn_val",        if_w.val,    16'h9999);
    check("wrapdn_borrow",     if_w.borrow, 1);
    check("wrapdn_carry",      if_w.carry,  0);
    check("wrapdn_zero",       if_w.zero,   0);
    check("wrapdn_sat_val",    if_s.val,    16'h0000);
    check("wrapdn_sat_borrow", if_s.borrow, 0);
    check("wrapdn_sat_zero",   if_s.zero,   1);
    tick();
    check("wrapdn_borrow_end", if_w.borrow, 0);

    // Load with a clamped digit wins over a coincident inc edge.
    inc      = 1'b1;
    load     = 1'b1;
    load_val = 16'h12F7;
    tick();
    check("clamp_val", if_w.val, 16'h1297);
    inc = 1'b0;
    tick();
    tick();
    tick();
    check("ldpri_wrap_hold", if_w.val, 16'h1297);
    check("ldpri_fast_hold", if_f.val, 16'h1297);
    load = 1'b0;
    tick();
    tick();
    check("ldpri_wrap", if_w.val, 16'h1297);
    check("ldpri_sat",  if_s.val, 16'h1297);
    check("ldpri_fast", if_f.val, 16'h1297);

    // Clear beats load.
    clear    = 1'b1;
    load     = 1'b1;
    load_val = 16'h1234;
    tick();
    check("clr_over_ld",      if_w.val,  16'h0000);
    check("clr_over_ld_zero", if_w.zero, 1);
    clear = 1'b0;
    load  = 1'b0;

    // Simultaneous inc and dec cancel.
    do_load(16'h0500);
    pulse(1'b1, 1'b1);
    tick();
    check("simul_val",    if_w.val,    16'h0500);
    check("simul_carry",  if_w.carry,  0);
    check("simul_borrow", if_w.borrow, 0);
    check("simul_fast",   if_f.val,    16'h0500);

    // A long level counts once.
    inc = 1'b1;
    repeat (20) tick();
    inc = 1'b0;
    tick();
    tick();
    check("level_wrap", if_w.val, 16'h0501);
    check("level_sat",  if_s.val, 16'h0501);
    check("level_fast", if_f.val, 16'h0501);

    // Asynchronous reset while an event is in flight.
    do_load(16'h0042);
    inc = 1'b1;
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("areset_val",  if_w.val,  16'h0000);
    check("areset_zero", if_w.zero, 1);
    check("areset_fast", if_f.val,  16'h0000);
    inc = 1'b0;
    @(posedge clk);
    #4;
    reset_n = 1'b1;
    tick();
    tick();
    tick();
    check("post_rst_wrap", if_w.val,  16'h0000);
    check("post_rst_sat",  if_s.val,  16'h0000);
    check("post_rst_fast", if_f.val,  16'h0000);
    check("post_rst_zero", if_f.zero, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_counter_n.md
# bcd_counter_n

Parametrised multi-digit BCD event counter with up/down counting, parallel load and selectable wrap or saturate behaviour. It counts rising edges on `inc`/`dec` strobes, which are optionally synchronised from another clock domain, and drives decimal digits directly to display and score logic. It is the next generation of our single-digit increment-only BCD counter: N digits in one block, ripple carry inside one cycle, carry/borrow pulses out for cascading.

## Interface
- `DIGITS`, 4: number of BCD digits (1..8); `val` width is 4*DIGITS.
- `SATURATE`, 0: 0 = wrap (all-9 up gives all-0, all-0 down gives all-9); 1 = hold at limits.
- `SYNC_IN`, 1: 1 = `inc`/`dec` pass through a 2-flop synchroniser before edge detect; 0 = treated as synchronous to `clk`.

- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `inc`  in  1  count-up strobe; each rising edge counts +1.
- `dec`  in  1  count-down strobe; each rising edge counts -1.
- `clear`  in  1  synchronous clear to 0, level-sensitive.
- `load`  in  1  synchronous parallel load, level-sensitive.
- `load_val`  in  4*DIGITS  load value, digit 0 in bits [3:0].
- `val`  out  4*DIGITS  current count, digit 0 least significant.
- `carry`  out  1  one-cycle pulse on wrap from all-9 to all-0.
- `borrow`  out  1  one-cycle pulse on wrap from all-0 to all-9.
- `zero`  out  1  high when `val` == 0 (combinational from `val`).

## Operation
- Edge detect: per strobe, sync stage(s) then one history flop; event = synced & ~history. Level-high strobes count once only.
- Priority per cycle: `clear` > `load` > count event. While `clear` or `load` is high, count events are discarded. They are not queued.
- Load: each digit of `load_val` greater than 9 is clamped to 9. Other digits load unchanged.
- Up event: digit 0 +1; a digit at 9 goes to 0 and passes carry to the next digit. The ripple runs through all digits in the same cycle.
- Down event: digit 0 -1; a digit at 0 goes to 9 and passes borrow to the next digit.
- Simultaneous `inc` and `dec` events in the same cycle: net zero. `val` does not change and no pulse is issued.
- Wrap mode: `carry` pulses when the top digit carries out. `borrow` pulses when the top digit borrows out.
- Saturate mode: an up event at all-9 and a down event at all-0 are ignored. `carry`/`borrow` never assert.
- `carry`/`borrow` are registered. They are high for exactly the cycle in which `val` shows the wrapped value.

## Timing
- Reset (`reset_n` low, asynchronous): `val`=0, `carry`=0, `borrow`=0, all sync and history flops = 0, so `zero`=1. Reset mid-count discards any event in flight.
- Edge latency with SYNC_IN=1: strobe first sampled high at edge E0 → `val` updates at E2.
- Edge latency with SYNC_IN=0: strobe first sampled high at E0 → `val` updates at E1.
- `clear`/`load` sampled at edge E → `val` updated at E, with no pipeline delay.
- Minimum strobe high time and low time: 1 `clk` period when SYNC_IN=0, 2 periods when SYNC_IN=1. Shorter pulses may be lost.
- Maximum count rate: one event per 2 cycles per strobe. `inc` and `dec` are independent.

## Structure
- Shared package `bcd_pkg`:
  - `BCD_MAX` = 4'd9 and `BCD_MIN` = 4'd0.
  - Mode constants `BCD_WRAP` and `BCD_SAT`.
  - Function `bcd_clamp(d)` for digit clamping.
- Sub-module `bcd_digit_updn`: one 4-bit digit register plus combinational next-state.
  - Inputs: `up`, `dn`, `ci`, `bi`, `clear`, `load`, `ld_digit`.
  - Outputs: `co`, `bo`, `d`.
  - Instantiated DIGITS times via generate, with the ci/co and bi/bo chains linked.
- The top level holds the strobe sync and edge-detect logic, the saturate gating (all-9 / all-0 detect) and the carry/borrow pulse registers.

## Test plan
- Reset and count: release `reset_n`, DIGITS=4, SYNC_IN=1, apply 10 single-cycle-wide 3-cycle `inc` pulses → `val`=0x0010, each update exactly 2 edges after first sampling.
- Wrap up: load 0x9999, WRAP, one `inc` edge → `val`=0x0000 and `carry`=1 for one cycle; `borrow`=0; `zero`=1.
- Wrap down and saturate:
  - WRAP: load 0x0000, one `dec` → `val`=0x9999, one `borrow` pulse.
  - SATURATE=1: repeat the same stimulus → `val` stays 0x0000, no pulse.
- Priority and clamp:
  - `load`=1 with `load_val`=0x12F7 together with an `inc` edge → `val`=0x1297 and the inc is lost.
  - `clear` and `load` both high → `val`=0.
- Simultaneous and level inputs:
  - `inc` and `dec` edges in the same cycle from 0x0500 → `val` stays 0x0500.
  - `inc` held high for 20 cycles → exactly one increment.
- Async reset mid-operation: assert `reset_n` low between a strobe edge and the `val` update → `val`=0 immediately, and no update follows the release.
